// File: rtl/stream_host_driver_if.sv
//------------------------------------------------------------------------------
// stream_host_driver_if : local source/sink streams plus stream-cipher chip pins
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface stream_host_driver_if #(
  parameter int DATA_W = 8
);
  // Local plaintext source
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  // Chip pins
  logic [DATA_W-1:0] chip_data_out;
  logic              chip_request;
  logic              chip_acknowledge;
  logic              chip_done;
  logic [DATA_W-1:0] chip_data_in;
  // Local ciphertext sink
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;

  modport master (
    input  tx_data, tx_valid, chip_done, chip_data_in,
    output tx_ready, chip_data_out, chip_request, chip_acknowledge, rx_data, rx_valid
  );

  modport slave (
    output tx_data, tx_valid, chip_done, chip_data_in,
    input  tx_ready, chip_data_out, chip_request, chip_acknowledge, rx_data, rx_valid
  );
endinterface

`default_nettype wire

// File: rtl/stream_host_driver.sv
//------------------------------------------------------------------------------
// stream_host_driver : four-phase request/acknowledge initiator for the cipher chip
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module stream_host_driver #(
  parameter int DATA_W         = 8,
  parameter int LEN_W          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int TMO_W          = 8
) (
  input  wire logic             clk,
  input  wire logic             nrst,
  input  wire logic             start_i,
  input  wire logic [LEN_W-1:0] len_i,
  stream_host_driver_if.master  bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_err_o
);

  typedef enum logic [1:0] {
    H_IDLE  = 2'd0,
    H_FETCH = 2'd1,
    H_REQ   = 2'd2,
    H_ACK   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              req_q, req_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              done_q, done_d;
  logic              terr_q, terr_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   done_s;
  logic                   tmo_hit;
  logic                   tx_ready;
  logic [LEN_W-1:0]       cnt_inc;

  // chip_done is asynchronous to clk; only the synchronized copy steers the FSM
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.chip_done};
    end
  end

  assign done_s = sync_q[SYNC_STAGES-1];

  generate
    if (TIMEOUT_CYCLES != 0) begin : g_tmo_on
      assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_tmo_off
      assign tmo_hit = 1'b0;
    end
  endgenerate

  // Gating with done_s keeps a new request from rising while the chip is still DONE
  assign tx_ready = (state_q == H_FETCH) && !done_s;
  assign cnt_inc  = cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    data_out_d = data_out_q;
    req_d      = req_q;
    ack_d      = ack_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    done_d     = 1'b0;
    terr_d     = terr_q;

    case (state_q)
      H_IDLE: begin
        if (start_i) begin
          terr_d = 1'b0;
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            len_d   = len_i;
            cnt_d   = '0;
            state_d = H_FETCH;
          end
        end
      end

      H_FETCH: begin
        if (bus.tx_valid && tx_ready) begin
          data_out_d = bus.tx_data;
          req_d      = 1'b1;
          tmo_d      = '0;
          state_d    = H_REQ;
        end
      end

      H_REQ: begin
        // The awaited edge takes priority over a coincident timeout
        if (done_s) begin
          rx_data_d  = bus.chip_data_in;
          rx_valid_d = 1'b1;
          req_d      = 1'b0;
          ack_d      = 1'b1;
          tmo_d      = '0;
          state_d    = H_ACK;
        end else if (tmo_hit) begin
          req_d   = 1'b0;
          ack_d   = 1'b0;
          terr_d  = 1'b1;
          state_d = H_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      H_ACK: begin
        if (!done_s) begin
          ack_d = 1'b0;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            done_d  = 1'b1;
            state_d = H_IDLE;
          end else begin
            state_d = H_FETCH;
          end
        end else if (tmo_hit) begin
          req_d   = 1'b0;
          ack_d   = 1'b0;
          terr_d  = 1'b1;
          state_d = H_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: begin
        state_d = H_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= H_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      data_out_q <= '0;
      req_q      <= 1'b0;
      ack_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      data_out_q <= data_out_d;
      req_q      <= req_d;
      ack_q      <= ack_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      done_q     <= done_d;
      terr_q     <= terr_d;
    end
  end

  assign bus.tx_ready         = tx_ready;
  assign bus.chip_data_out    = data_out_q;
  assign bus.chip_request     = req_q;
  assign bus.chip_acknowledge = ack_q;
  assign bus.rx_data          = rx_data_q;
  assign bus.rx_valid         = rx_valid_q;

  assign busy_o        = (state_q != H_IDLE);
  assign done_o        = done_q;
  assign timeout_err_o = terr_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_host_driver.sv
//------------------------------------------------------------------------------
// tb_stream_host_driver : chip model plus scoreboard bench for stream_host_driver
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_stream_host_driver;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;
  localparam int SYNC   = 2;
  localparam int TMO    = 16;

  logic             clk     = 1'b0;
  logic             nrst    = 1'b0;
  logic             start_i = 1'b0;
  logic [LEN_W-1:0] len_i   = '0;
  logic             busy_o;
  logic             done_o;
  logic             terr_o;

  stream_host_driver_if #(.DATA_W(DATA_W)) bus ();

  stream_host_driver #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .SYNC_STAGES(SYNC),
    .TIMEOUT_CYCLES(TMO), .TMO_W(8)
  ) dut (
    .clk(clk), .nrst(nrst), .start_i(start_i), .len_i(len_i), .bus(bus),
    .busy_o(busy_o), .done_o(done_o), .timeout_err_o(terr_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Chip model: raises done chip_lat cycles into a request, drops it once acknowledged
  bit         chip_en  = 1'b1;
  logic [7:0] chip_key = 8'h00;
  int         chip_lat = 3;

  initial begin
    int st;
    int cnt;
    st = 0;
    cnt = 0;
    bus.chip_done    = 1'b0;
    bus.chip_data_in = '0;
    forever begin
      @(negedge clk);
      if (!nrst || !chip_en) begin
        bus.chip_done = 1'b0;
        st = 0;
        cnt = 0;
      end else if (st == 0) begin
        if (bus.chip_request) begin
          cnt++;
          if (cnt >= chip_lat) begin
            bus.chip_data_in = bus.chip_data_out ^ chip_key;
            bus.chip_done    = 1'b1;
            st  = 1;
            cnt = 0;
          end
        end else begin
          cnt = 0;
        end
      end else if (bus.chip_acknowledge) begin
        bus.chip_done = 1'b0;
        st = 0;
      end
    end
  end

  // Independent copy of the done synchronizer, for handshake-ordering checks
  logic [SYNC-1:0] ds_q;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) ds_q <= '0;
    else       ds_q <= {ds_q[SYNC-2:0], bus.chip_done};
  end

  logic [7:0] sb[$];
  logic [7:0] req_words[$];
  int   rx_cnt = 0, req_rises = 0, done_cnt = 0, req_len = 0, last_req_len = 0, rule_bad = 0;
  logic prev_req = 1'b0, prev_ack = 1'b0, prev_ds = 1'b0;
  logic [7:0] held = 8'h00;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!nrst) begin
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_ds  = 1'b0;
        req_len  = 0;
      end else begin
        if (bus.rx_valid) begin
          rx_cnt++;
          chk("rx_after_ds", 32'(prev_ds), 32'd1);
          if (sb.size() == 0) chk("rx_unexpected", 32'(sb.size()), 32'd1);
          else                chk("rx_data", 32'(bus.rx_data), 32'(sb.pop_front()));
        end
        if (bus.chip_request && !prev_req) begin
          req_rises++;
          held = bus.chip_data_out;
          req_words.push_back(held);
          if (prev_ds) rule_bad++;
        end
        if (bus.chip_request && prev_req && bus.chip_data_out !== held) rule_bad++;
        if (bus.chip_request && bus.chip_acknowledge) rule_bad++;
        if (bus.chip_request) begin
          req_len++;
        end else if (prev_req) begin
          last_req_len = req_len;
          req_len = 0;
        end
        if (!bus.chip_acknowledge && prev_ack && terr_o === 1'b0)
          chk("ack_fall_after_ds_low", 32'(prev_ds), 32'd0);
        if (done_o) done_cnt++;
        prev_req = bus.chip_request;
        prev_ack = bus.chip_acknowledge;
        prev_ds  = ds_q[SYNC-1];
      end
    end
  end

  task automatic do_start(input logic [7:0] n);
    @(negedge clk);
    start_i = 1'b1;
    len_i   = n;
    @(negedge clk);
    start_i = 1'b0;
    len_i   = 8'hEE;
  endtask

  task automatic feed(input logic [7:0] w, input bit last, input bit expect_rx);
    int k;
    k = 0;
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      chk("tx_wait", 32'(bus.tx_ready), 32'd1);
      bus.tx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (expect_rx) sb.push_back(w ^ chip_key);
    if (last) bus.tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0, r0, q0, k;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({bus.chip_request, bus.chip_acknowledge, bus.rx_valid,
                         done_o, terr_o, busy_o}), 32'd0);
    chk("rst_data", 32'({bus.chip_data_out, bus.rx_data}), 32'd0);
    nrst = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'({bus.tx_ready, busy_o}), 32'd0);

    // Single word
    chip_key = 8'h99;
    d0 = done_cnt; r0 = rx_cnt;
    do_start(8'd1);
    feed(8'hA5, 1'b1, 1'b1);
    wait_done(d0);
    chk("t1_req_word", 32'(req_words[req_words.size()-1]), 32'hA5);
    chk("t1_rx_data", 32'(bus.rx_data), 32'h3C);
    chk("t1_rx_cnt", 32'(rx_cnt - r0), 32'd1);
    chk("t1_busy", 32'(busy_o), 32'd0);

    // Burst with source always valid
    chip_key = 8'hFF;
    d0 = done_cnt; r0 = rx_cnt; q0 = req_rises;
    do_start(8'd3);
    feed(8'h01, 1'b0, 1'b1);
    feed(8'h02, 1'b0, 1'b1);
    feed(8'h03, 1'b1, 1'b1);
    wait_done(d0);
    chk("t2_req_pulses", 32'(req_rises - q0), 32'd3);
    chk("t2_rx_cnt", 32'(rx_cnt - r0), 32'd3);
    chk("t2_rx_last", 32'(bus.rx_data), 32'hFC);

    // Zero length
    d0 = done_cnt;
    @(negedge clk);
    start_i = 1'b1;
    len_i   = 8'd0;
    @(negedge clk);
    start_i = 1'b0;
    chk("t3_done_hi", 32'(done_o), 32'd1);
    chk("t3_quiet", 32'({bus.chip_request, bus.tx_ready, busy_o}), 32'd0);
    @(negedge clk);
    chk("t3_done_lo", 32'(done_o), 32'd0);
    chk("t3_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Source stall in H_FETCH
    chip_key = 8'h5A;
    d0 = done_cnt;
    do_start(8'd1);
    for (int i = 0; i < 10; i++) begin
      chk("t4_stall", 32'({bus.tx_ready, bus.chip_request, terr_o}), 32'b100);
      @(negedge clk);
    end
    feed(8'h77, 1'b1, 1'b1);
    wait_done(d0);

    // Timeout: chip never answers
    chip_en = 1'b0;
    d0 = done_cnt; r0 = rx_cnt;
    do_start(8'd1);
    feed(8'h11, 1'b1, 1'b0);
    k = 0;
    while (!terr_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("t5_terr", 32'(terr_o), 32'd1);
    chk("t5_req_len", 32'(last_req_len), 32'd16);
    chk("t5_idle", 32'({busy_o, bus.chip_request, bus.chip_acknowledge}), 32'd0);
    chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t5_no_rx", 32'(rx_cnt - r0), 32'd0);
    chip_en  = 1'b1;
    chip_key = 8'h0F;
    d0 = done_cnt;
    do_start(8'd1);
    chk("t5_terr_clr", 32'(terr_o), 32'd0);
    feed(8'h22, 1'b1, 1'b1);
    wait_done(d0);

    // Reset while acknowledge is high
    chip_key = 8'h33;
    do_start(8'd1);
    feed(8'h44, 1'b1, 1'b1);
    k = 0;
    while (!bus.chip_acknowledge && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_in_ack", 32'(bus.chip_acknowledge), 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    chk("t6_async_ctrl", 32'({bus.chip_request, bus.chip_acknowledge, bus.rx_valid,
                              done_o, terr_o, busy_o, bus.tx_ready}), 32'd0);
    chk("t6_async_data", 32'({bus.chip_data_out, bus.rx_data}), 32'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_post_idle", 32'({busy_o, bus.chip_request, bus.tx_ready}), 32'd0);

    chk("handshake_rules", 32'(rule_bad), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=no_finish exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/stream_host_driver.md
# stream_host_driver

Host-side initiator for the stream cipher chip's request/acknowledge pin handshake. It fetches plaintext words from a local source and presents each one on the chip's data pins. It then raises the request, waits for the chip's done indication, captures the cipher word into a local sink and completes the handshake with the acknowledge. It sits on the bench/companion side of the chip pins, driving the chip's input-request and output-acknowledge inputs and observing its done state.

## Interface
Parameters:
- DATA_W, 8, width of plaintext/ciphertext words
- LEN_W, 8, width of the burst length field
- SYNC_STAGES, 2, flops in the chip_done synchronizer (min 2)
- TIMEOUT_CYCLES, 200, max cycles waiting in H_REQ or H_ACK; 0 disables timeout
- TMO_W, 8, timeout counter width; must satisfy TIMEOUT_CYCLES < 2^TMO_W

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- start  in  1  burst start pulse, sampled only in H_IDLE
- len  in  LEN_W  number of words in the burst, latched on accepted start
- tx_data  in  DATA_W  plaintext word from local source
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  combinational, high only in H_FETCH
- chip_data_out  out  DATA_W  registered word driven to chip data pins
- chip_request  out  1  registered request to chip
- chip_acknowledge  out  1  registered acknowledge to chip
- chip_done  in  1  asynchronous level, high while chip is in its DONE state
- chip_data_in  in  DATA_W  cipher word from chip, stable while chip_done is high
- rx_data  out  DATA_W  captured cipher word
- rx_valid  out  1  one-cycle pulse with rx_data
- busy  out  1  high in every state except H_IDLE
- done  out  1  one-cycle pulse on successful burst completion
- timeout_err  out  1  sticky timeout flag

## Operation
- Reset: state H_IDLE. All registered outputs reset to 0: chip_data_out, chip_request, chip_acknowledge, rx_data, rx_valid, done, timeout_err. Word counter, timeout counter and synchronizer flops also reset to 0.
- done_s is chip_done after SYNC_STAGES flops. All FSM decisions use done_s only.
- States: H_IDLE, H_FETCH, H_REQ, H_ACK.
- H_IDLE:
  - start=1 with len=0: done pulses and timeout_err clears; state stays H_IDLE.
  - start=1 with len≠0: latch len, clear the word counter, clear timeout_err, go to H_FETCH.
- H_FETCH:
  - tx_ready=1.
  - On tx_valid: register tx_data into chip_data_out, set chip_request=1, clear the timeout counter, go to H_REQ.
- H_REQ:
  - Hold chip_request=1 and chip_data_out stable.
  - On done_s=1: capture chip_data_in into rx_data, pulse rx_valid, set chip_request=0 and chip_acknowledge=1, clear the timeout counter, go to H_ACK.
- H_ACK:
  - Hold chip_acknowledge=1.
  - On done_s=0: set chip_acknowledge=0 and increment the word counter.
  - If the incremented count equals len: pulse done and go to H_IDLE. Otherwise go to H_FETCH.
- Four-phase rule: request is never asserted while done_s=1. Request and acknowledge are never high in the same cycle.
- Timeout (TIMEOUT_CYCLES≠0):
  - The counter increments on every cycle spent in H_REQ or H_ACK.
  - When it reaches TIMEOUT_CYCLES-1 and the awaited done_s edge has not arrived, the next edge clears chip_request and chip_acknowledge, sets timeout_err=1 and goes to H_IDLE. done does not pulse.
  - If the awaited event and the timeout occur in the same cycle, the event wins.
- start outside H_IDLE is ignored.
- len changes after start are ignored.
- The word counter is LEN_W wide and cannot wrap, because bursts terminate at count==len.
- Reset mid-operation: outputs drop to 0 asynchronously, which removes request/acknowledge at the pins immediately. The chip-side recovery is the chip's own responsibility.

## Timing
- Every transition takes effect at the posedge after its condition is sampled.
- chip_request rises one cycle after the tx_valid&tx_ready handshake.
- done_s lags chip_done by SYNC_STAGES cycles.
- rx_valid and chip_acknowledge rise one cycle after done_s=1 is seen in H_REQ.
- chip_acknowledge falls one cycle after done_s=0 is seen in H_ACK.
- Minimum per-word period with a zero-latency chip and tx_valid always high: 4 + 2·SYNC_STAGES cycles.
- done is asserted in the same cycle that busy deasserts.

## Test plan
- Single word:
  - Stimulus: len=1, tx_data=0xA5, chip model raises done 3 cycles after request with 0x3C.
  - Required: chip_data_out=0xA5 while request is high, rx_data=0x3C with a single rx_valid pulse, acknowledge high until done_s falls, then one done pulse and busy=0.
- Burst:
  - Stimulus: len=3, tx_valid held high with words 0x01/0x02/0x03, chip returns XOR 0xFF.
  - Required: rx sequence 0xFE/0xFD/0xFC, exactly 3 request pulses, request never high while done_s=1.
- Zero length:
  - Stimulus: start with len=0.
  - Required: done pulses one cycle later, chip_request stays 0, tx_ready stays 0.
- Source stall:
  - Stimulus: tx_valid low for 10 cycles in H_FETCH.
  - Required: tx_ready=1 throughout, request stays 0, timeout_err stays 0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16, chip never raises done.
  - Required: request drops after 16 cycles in H_REQ, timeout_err=1, no done pulse. A following start with len=1 clears timeout_err.
- Reset mid-H_ACK:
  - Stimulus: assert nrst=0 while chip_acknowledge=1.
  - Required: all outputs read 0 before the next clk edge; after release the block sits in H_IDLE with busy=0.
